// File: rtl/key_event_pkg.sv
// Shared clock-project constants: key/time-set controller state encodings.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } key_state_e;

endpackage : key_event_pkg

// File: rtl/key_event_tick_div.sv
// Free-running prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module tick_div #(
    parameter int TICK_DIV = 50000
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic ien,
    output logic otick
);

    localparam int W = $clog2(TICK_DIV + 1);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    if (TICK_DIV < 1) begin : g_param_check
        $error("tick_div: TICK_DIV must be >= 1");
    end

    logic [W-1:0] cnt;

    // Gating with ien keeps the TICK_DIV=1 case quiet while disabled.
    assign otick = ien && (cnt == LAST);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt <= '0;
        end else if (!ien || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : tick_div

// File: rtl/key_event.sv
// Key hold classifier: press, long-press, auto-repeat and release pulses from a debounced key level.
module key_event
    import key_event_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int LONG_TICKS = 800,
    parameter int REP_TICKS  = 150
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic iin,
    output logic ostep,
    output logic olong,
    output logic orep,
    output logic orel,
    output logic oheld
);

    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int RW = $clog2(REP_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
    localparam logic [RW-1:0] REP_MAX  = RW'(REP_TICKS);

    if (LONG_TICKS < 1 || REP_TICKS < 1) begin : g_param_check
        $error("key_event: LONG_TICKS and REP_TICKS must be >= 1");
    end

    key_state_e    state;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          run;
    logic          tick;

    assign run = (state != IDLE);

    tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .iclk  (iclk),
        .irst_n(irst_n),
        .ien   (run),
        .otick (tick)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            ostep    <= 1'b0;
            olong    <= 1'b0;
            orep     <= 1'b0;
            orel     <= 1'b0;
            oheld    <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; only the firing branch raises one, which keeps them exclusive.
            ostep <= 1'b0;
            olong <= 1'b0;
            orep  <= 1'b0;
            orel  <= 1'b0;
            case (state)
                IDLE: begin
                    if (iin) begin
                        state    <= PRESS;
                        ostep    <= 1'b1;
                        oheld    <= 1'b1;
                        hold_cnt <= '0;
                        rep_cnt  <= '0;
                    end
                end
                PRESS: begin
                    if (!iin) begin
                        state <= IDLE;
                        orel  <= 1'b1;
                        oheld <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_MAX - 1'b1) begin
                            state    <= LONG;
                            hold_cnt <= HOLD_MAX;
                            rep_cnt  <= '0;
                            olong    <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                LONG: begin
                    // Release wins over a repeat that falls due on the same edge.
                    if (!iin) begin
                        state <= IDLE;
                        orel  <= 1'b1;
                        oheld <= 1'b0;
                    end else if (tick) begin
                        if (rep_cnt == REP_MAX - 1'b1) begin
                            rep_cnt <= '0;
                            orep    <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    oheld <= 1'b0;
                end
            endcase
        end
    end

endmodule : key_event
